// File: rtl/fir_pkg.sv
// Shared definitions for the programmable transposed-direct-form FIR.
//   state_e     : control FSM state (RUN streams samples, LOAD takes coefficients)
//   calc_bw_acc : accumulator width that cannot overflow for N_TAPS full-scale products
package fir_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    LOAD = 1'b1
  } state_e;

  function automatic int calc_bw_acc(input int bw_in, input int bw_coef, input int n_taps);
    return bw_in + bw_coef + $clog2(n_taps);
  endfunction

endpackage

// File: rtl/fir_out_stage.sv
// Output stage: round half up, arithmetic shift right by SHIFT, saturate to
// BW_OUT bits, then register.
//   clk, reset : clock, synchronous active-high reset
//   vld_i      : acc_i holds a fresh filter result this cycle
//   acc_i      : signed accumulator value (sum[0])
//   vld_o      : single-cycle strobe, y_o updated
//   y_o        : signed result, holds between strobes
//   sat_o      : strobe qualified by vld_o, result was clamped
module fir_out_stage
  import fir_pkg::*;
#(
  parameter int BW_ACC = 10,
  parameter int BW_OUT = 8,
  parameter int SHIFT  = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     vld_i,
  input  logic signed [BW_ACC-1:0] acc_i,
  output logic                     vld_o,
  output logic signed [BW_OUT-1:0] y_o,
  output logic                     sat_o
);

  // Working width leaves headroom for the rounding add and for BW_OUT > BW_ACC.
  localparam int WX = ((BW_ACC + 1 > BW_OUT) ? BW_ACC + 1 : BW_OUT) + 1;
  localparam logic signed [WX-1:0] RND  = WX'((1 << SHIFT) >> 1);
  localparam logic signed [WX-1:0] MAXV = WX'((2 ** (BW_OUT - 1)) - 1);
  localparam logic signed [WX-1:0] MINV = ~MAXV;

  logic signed [WX-1:0]     ext, rnd, shr;
  logic                     hi, lo;
  logic signed [BW_OUT-1:0] y_d;
  logic                     vld_q, sat_q;
  logic signed [BW_OUT-1:0] y_q;

  assign ext = {{(WX-BW_ACC){acc_i[BW_ACC-1]}}, acc_i};
  assign rnd = ext + RND;
  assign shr = rnd >>> SHIFT;
  assign hi  = shr > MAXV;
  assign lo  = shr < MINV;
  assign y_d = hi ? MAXV[BW_OUT-1:0] : (lo ? MINV[BW_OUT-1:0] : shr[BW_OUT-1:0]);

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= 1'b0;
      sat_q <= 1'b0;
      y_q   <= '0;
    end else begin
      vld_q <= vld_i;
      sat_q <= vld_i & (hi | lo);
      if (vld_i) y_q <= y_d;
    end
  end

  assign vld_o = vld_q;
  assign y_o   = y_q;
  assign sat_o = sat_q;

endmodule

// File: rtl/fir_tdf_prog.sv
// Transposed-direct-form FIR with run-time loadable coefficients.
//   clk, reset             : clock, synchronous active-high reset
//   in_valid/in_ready/x_in : sample handshake, accepted when both high
//   coef_load              : pulse in RUN to start a coefficient load
//   coef_valid/coef_in     : coefficient words during LOAD, c[0] first
//   out_valid/y_out/sat    : result strobe two cycles after accept
module fir_tdf_prog
  import fir_pkg::*;
#(
  parameter int N_TAPS  = 4,
  parameter int BW_IN   = 4,
  parameter int BW_COEF = 4,
  parameter int BW_OUT  = 8,
  parameter int SHIFT   = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [BW_IN-1:0]   x_in,
  input  logic                      coef_load,
  input  logic                      coef_valid,
  input  logic signed [BW_COEF-1:0] coef_in,
  output logic                      out_valid,
  output logic signed [BW_OUT-1:0]  y_out,
  output logic                      sat
);

  localparam int BW_ACC = calc_bw_acc(BW_IN, BW_COEF, N_TAPS);
  localparam int BW_P   = BW_IN + BW_COEF;
  localparam int CW     = $clog2(N_TAPS);
  // Passthrough: c[0]=1, all others 0.
  localparam logic [N_TAPS-1:0][BW_COEF-1:0] COEF_INIT = (N_TAPS*BW_COEF)'(1);

  state_e                          state_q, state_d;
  logic [CW-1:0]                   cnt_q, cnt_d;
  logic [N_TAPS-1:0][BW_COEF-1:0]  coef_q;
  logic [N_TAPS-1:0][BW_ACC-1:0]   sum_q, sum_d;
  logic                            accept, last_word, acc_vld_q;
  logic signed [BW_P-1:0]          x_ext;

  assign accept    = in_valid && (state_q == RUN);
  assign last_word = (state_q == LOAD) && coef_valid && (cnt_q == CW'(N_TAPS - 1));

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN:  if (coef_load) state_d = LOAD;
      LOAD: begin
        if (last_word) begin
          state_d = RUN;
          cnt_d   = '0;
        end else if (coef_valid) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = RUN;
    endcase
  end

  // FSM: outputs, decoded from the state register only
  always_comb begin
    in_ready = (state_q == RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) coef_q <= COEF_INIT;
    else if ((state_q == LOAD) && coef_valid) coef_q[cnt_q] <= coef_in;
  end

  assign x_ext = {{BW_COEF{x_in[BW_IN-1]}}, x_in};

  for (genvar k = 0; k < N_TAPS; k++) begin : g_tap
    logic signed [BW_P-1:0]   c_ext, prod;
    logic signed [BW_ACC-1:0] prod_ext;
    assign c_ext    = {{BW_IN{coef_q[k][BW_COEF-1]}}, coef_q[k]};
    assign prod     = x_ext * c_ext;
    assign prod_ext = {{(BW_ACC-BW_P){prod[BW_P-1]}}, prod};
    if (k == N_TAPS - 1) begin : g_last
      assign sum_d[k] = prod_ext;
    end else begin : g_mid
      assign sum_d[k] = prod_ext + sum_q[k+1];
    end
  end

  // A finished load starts the new filter from an empty delay line.
  always_ff @(posedge clk) begin
    if (reset || last_word) sum_q <= '0;
    else if (accept)        sum_q <= sum_d;
  end

  always_ff @(posedge clk) begin
    if (reset) acc_vld_q <= 1'b0;
    else       acc_vld_q <= accept;
  end

  fir_out_stage #(
    .BW_ACC (BW_ACC),
    .BW_OUT (BW_OUT),
    .SHIFT  (SHIFT)
  ) u_out (
    .clk   (clk),
    .reset (reset),
    .vld_i (acc_vld_q),
    .acc_i (sum_q[0]),
    .vld_o (out_valid),
    .y_o   (y_out),
    .sat_o (sat)
  );

endmodule

// File: tb/tb_fir_tdf_prog.sv
module tb_fir_tdf_prog;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset, in_valid, coef_load, coef_valid;
  logic signed [3:0] x_in, coef_in;
  logic              in_ready, in_ready_r, out_valid, out_valid_r, sat, sat_r;
  logic signed [7:0] y_out, y_out_r;

  fir_tdf_prog dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in),
    .coef_load(coef_load), .coef_valid(coef_valid), .coef_in(coef_in),
    .out_valid(out_valid), .y_out(y_out), .sat(sat));

  fir_tdf_prog #(.SHIFT(2)) dut_r (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_r), .x_in(x_in),
    .coef_load(coef_load), .coef_valid(coef_valid), .coef_in(coef_in),
    .out_valid(out_valid_r), .y_out(y_out_r), .sat(sat_r));

  int checks = 0, failures = 0;

  // Reference model: coefficient list, history of accepted samples (newest
  // first), load progress, and a one-deep queue of pending results.
  int mc[4];
  int hist[$];
  bit mload;
  int mcnt;
  bit pv, ps0, ps2;
  int py0, py2;
  bit ev, es0, es2;
  int ey0, ey2;
  bit rdy_exp, rdy_obs, rdy_obs_r;
  int got0[$], got2[$];

  function automatic int shaped(input int v, input int sh);
    int r;
    r = v;
    if (sh > 0) r = (r + (1 << (sh - 1))) >>> sh;
    if (r > 127) r = 127;
    if (r < -128) r = -128;
    return r;
  endfunction

  function automatic bit clipped(input int v, input int sh);
    int r;
    r = v;
    if (sh > 0) r = (r + (1 << (sh - 1))) >>> sh;
    return (r > 127) || (r < -128);
  endfunction

  task automatic model_reset();
    mc = '{1, 0, 0, 0};
    hist.delete();
    mload = 0; mcnt = 0;
    pv = 0; ev = 0; ey0 = 0; ey2 = 0; es0 = 0; es2 = 0;
  endtask

  task automatic do_reset();
    reset = 1; in_valid = 0; x_in = 0; coef_load = 0; coef_valid = 0; coef_in = 0;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    model_reset();
  endtask

  // One clock cycle of stimulus; advances the model across the same edge.
  task automatic tick(input bit iv, input int x, input bit cl, input bit cv, input int ci);
    int full;
    in_valid = iv; x_in = 4'(x); coef_load = cl; coef_valid = cv; coef_in = 4'(ci);
    #1;
    rdy_obs = in_ready; rdy_obs_r = in_ready_r; rdy_exp = !mload;
    @(posedge clk); #1;
    ev = pv;
    if (pv) begin ey0 = py0; ey2 = py2; end
    es0 = pv && ps0; es2 = pv && ps2;
    pv = iv && !mload;
    if (pv) begin
      hist.push_front(x);
      if (hist.size() > 4) void'(hist.pop_back());
      full = 0;
      foreach (hist[k]) full += mc[k] * hist[k];
      py0 = shaped(full, 0); ps0 = clipped(full, 0);
      py2 = shaped(full, 2); ps2 = clipped(full, 2);
    end
    if (mload) begin
      if (cv) begin
        mc[mcnt] = ci;
        if (mcnt == 3) begin mload = 0; mcnt = 0; hist.delete(); end
        else mcnt++;
      end
    end else if (cl) mload = 1;
  endtask

  task automatic load_coefs(input string name, input int c0, input int c1, input int c2, input int c3);
    int cs[4];
    cs = '{c0, c1, c2, c3};
    for (int i = 0; i < 5; i++) begin
      if (i == 0) tick(0, 0, 1, 0, 0); else tick(0, 0, 0, 1, cs[i-1]);
      checks++;
      if ({rdy_obs, rdy_obs_r} !== {rdy_exp, rdy_exp}) begin
        failures++; $display("FAIL %s in_ready got %0b/%0b want %0b", name, rdy_obs, rdy_obs_r, rdy_exp);
      end
      checks++;
      if ({out_valid, y_out, sat, out_valid_r, y_out_r, sat_r} !== {ev, 8'(ey0), es0, ev, 8'(ey2), es2}) begin
        failures++; $display("FAIL %s out got %0b %0d %0b / %0b %0d %0b want %0b %0d %0b / %0d %0b", name,
          out_valid, y_out, sat, out_valid_r, y_out_r, sat_r, ev, ey0, es0, ey2, es2);
      end
    end
  endtask

  // Streams samples back to back, then drains; records outputs of both DUTs.
  task automatic feed(input string name, input int xs[$]);
    got0.delete(); got2.delete();
    for (int i = 0; i < xs.size() + 2; i++) begin
      if (i < xs.size()) tick(1, xs[i], 0, 0, 0); else tick(0, 0, 0, 0, 0);
      checks++;
      if ({rdy_obs, rdy_obs_r} !== {rdy_exp, rdy_exp}) begin
        failures++; $display("FAIL %s in_ready got %0b/%0b want %0b", name, rdy_obs, rdy_obs_r, rdy_exp);
      end
      checks++;
      if ({out_valid, y_out, sat, out_valid_r, y_out_r, sat_r} !== {ev, 8'(ey0), es0, ev, 8'(ey2), es2}) begin
        failures++; $display("FAIL %s out got %0b %0d %0b / %0b %0d %0b want %0b %0d %0b / %0d %0b", name,
          out_valid, y_out, sat, out_valid_r, y_out_r, sat_r, ev, ey0, es0, ey2, es2);
      end
      if (out_valid) got0.push_back(int'(y_out));
      if (out_valid_r) got2.push_back(int'(y_out_r));
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({in_ready, in_ready_r, out_valid, out_valid_r, sat, sat_r, y_out, y_out_r} !== {6'b110000, 16'h0}) begin
      failures++; $display("FAIL reset_state got rdy=%0b vld=%0b sat=%0b y=%0d want rdy=1 vld=0 sat=0 y=0",
        in_ready, out_valid, sat, y_out);
    end
  endtask

  task automatic test_passthrough();
    int e0[$];
    e0 = '{5, -8};
    do_reset();
    feed("passthrough", '{5, -8});
    checks++;
    if (got0 != e0) begin failures++; $display("FAIL passthrough_seq got %p want %p", got0, e0); end
  endtask

  task automatic test_impulse();
    int e0[$], e2[$];
    e0 = '{1, 2, 3, 4, 0}; e2 = '{0, 1, 1, 1, 0};
    do_reset();
    load_coefs("impulse_load", 1, 2, 3, 4);
    feed("impulse", '{1, 0, 0, 0, 0});
    checks++;
    if (got0 != e0) begin failures++; $display("FAIL impulse_seq got %p want %p", got0, e0); end
    checks++;
    if (got2 != e2) begin failures++; $display("FAIL impulse_seq_shift got %p want %p", got2, e2); end
  endtask

  task automatic test_saturation();
    int e0[$], e2[$];
    e0 = '{64, 127, 127, 127}; e2 = '{16, 32, 48, 64};
    do_reset();
    load_coefs("sat_load", -8, -8, -8, -8);
    feed("saturation", '{-8, -8, -8, -8});
    checks++;
    if (got0 != e0) begin failures++; $display("FAIL saturation_seq got %p want %p", got0, e0); end
    checks++;
    if (got2 != e2) begin failures++; $display("FAIL saturation_seq_shift got %p want %p", got2, e2); end
  endtask

  task automatic test_rounding();
    int e2[$];
    e2 = '{2, -1, 1};
    do_reset();
    feed("rounding", '{6, -6, 5});
    checks++;
    if (got2 != e2) begin failures++; $display("FAIL rounding_seq got %p want %p", got2, e2); end
  endtask

  task automatic test_load_midstream();
    int cs[4];
    int w, lowcnt, x, x9;
    bit cl, cv;
    cs = '{2, -1, 1, 1};
    w = 0; lowcnt = 0; x9 = 0;
    do_reset();
    for (int cyc = 0; cyc < 13; cyc++) begin
      x  = int'($urandom_range(0, 15)) - 8;
      cl = (cyc == 3);
      cv = (cyc >= 4) && (cyc <= 8) && (cyc != 6);
      if (cyc == 9) x9 = x;
      tick(1, x, cl, cv, cv ? cs[w] : 0);
      if (cv) w++;
      if (!rdy_obs) lowcnt++;
      checks++;
      if ({rdy_obs, rdy_obs_r} !== {rdy_exp, rdy_exp}) begin
        failures++; $display("FAIL midload in_ready cyc %0d got %0b want %0b", cyc, rdy_obs, rdy_exp);
      end
      checks++;
      if ({out_valid, y_out, sat, out_valid_r, y_out_r, sat_r} !== {ev, 8'(ey0), es0, ev, 8'(ey2), es2}) begin
        failures++; $display("FAIL midload out cyc %0d got %0b %0d %0b want %0b %0d %0b", cyc,
          out_valid, y_out, sat, ev, ey0, es0);
      end
      if (cyc == 4) begin
        checks++;
        if (out_valid !== 1'b1) begin failures++; $display("FAIL midload_inflight got %0b want 1", out_valid); end
      end
      if (cyc == 10) begin
        checks++;
        if ({out_valid, y_out} !== {1'b1, 8'(2 * x9)}) begin
          failures++; $display("FAIL midload_first_post got %0b %0d want 1 %0d", out_valid, y_out, 2 * x9);
        end
      end
    end
    checks++;
    if (lowcnt != 5) begin failures++; $display("FAIL midload_ready_low got %0d want 5", lowcnt); end
  endtask

  task automatic test_reset_midload();
    int e0[$];
    e0 = '{3};
    do_reset();
    tick(0, 0, 1, 0, 0);
    tick(0, 0, 0, 1, 5);
    tick(0, 0, 0, 1, 6);
    do_reset();
    checks++;
    if ({in_ready, in_ready_r} !== 2'b11) begin
      failures++; $display("FAIL reset_midload_ready got %0b want 1", in_ready);
    end
    feed("reset_midload", '{3});
    checks++;
    if (got0 != e0) begin failures++; $display("FAIL reset_midload_seq got %p want %p", got0, e0); end
  endtask

  task automatic test_random();
    bit iv, cl, cv;
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      iv = ($urandom_range(0, 3) != 0);
      cl = ($urandom_range(0, 39) == 0);
      cv = ($urandom_range(0, 2) != 0);
      tick(iv, int'($urandom_range(0, 15)) - 8, cl, cv, int'($urandom_range(0, 15)) - 8);
      checks++;
      if ({rdy_obs, rdy_obs_r} !== {rdy_exp, rdy_exp}) begin
        failures++; $display("FAIL random in_ready cyc %0d got %0b want %0b", cyc, rdy_obs, rdy_exp);
      end
      checks++;
      if ({out_valid, y_out, sat, out_valid_r, y_out_r, sat_r} !== {ev, 8'(ey0), es0, ev, 8'(ey2), es2}) begin
        failures++; $display("FAIL random out cyc %0d got %0b %0d %0b / %0b %0d %0b want %0b %0d %0b / %0d %0b", cyc,
          out_valid, y_out, sat, out_valid_r, y_out_r, sat_r, ev, ey0, es0, ey2, es2);
      end
    end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_impulse();
    test_saturation();
    test_rounding();
    test_load_midstream();
    test_reset_midload();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fir_tdf_prog.md
# fir_tdf_prog

Parametrised transposed-direct-form FIR filter with run-time loadable coefficients, valid/ready sample handshake, and a rounding/saturating output stage. It is the scalable successor to the fixed 2-tap filter in the tile top level. It sits between the pin-level sample input and `io_out`. A top-level wrapper maps pins onto its ports.

## Interface
- `N_TAPS`, 4: number of taps, ≥2
- `BW_IN`, 4: signed input sample width
- `BW_COEF`, 4: signed coefficient width
- `BW_OUT`, 8: signed output width
- `SHIFT`, 0: arithmetic right shift applied before saturation, 0..BW_ACC-1
- Derived, not overridable: `BW_ACC` = BW_IN+BW_COEF+$clog2(N_TAPS)
- `clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high
- `in_valid`  in  1  `x_in` carries a sample this cycle
- `in_ready`  out  1  high in RUN state; a sample is accepted when `in_valid && in_ready`
- `x_in`  in  BW_IN  signed sample
- `coef_load`  in  1  start a coefficient load (pulse)
- `coef_valid`  in  1  `coef_in` carries a coefficient word
- `coef_in`  in  BW_COEF  signed coefficient; the first word is c[0]
- `out_valid`  out  1  `y_out` valid this cycle
- `y_out`  out  BW_OUT  signed filter output
- `sat`  out  1  qualified by `out_valid`; `y_out` was clamped

## Operation
- FSM states:
  - RUN: `in_ready`=1. `coef_load`=1 moves the FSM to LOAD on the next cycle. `coef_valid` is ignored.
  - LOAD: `in_ready`=0. Each `coef_valid` writes `coef_in` to c[cnt] and increments `cnt`. The word where `cnt`=N_TAPS-1 zeroes all `sum[]`, clears `cnt`, and returns the FSM to RUN. `coef_load` and `in_valid` are ignored.
- Delay line, updated only on accept: `sum[k] <= x*c[k] + sum[k+1]` for k < N_TAPS-1, and `sum[N-1] <= x*c[N-1]`. When no sample is accepted, `sum[]` holds.
- Products are BW_IN+BW_COEF bits, sign-extended to BW_ACC. By construction the accumulator cannot overflow.
- Output stage, registered from `sum[0]` one cycle after an accept:
  - When SHIFT>0, add 2^(SHIFT-1) (round half up), then arithmetic shift right by SHIFT.
  - Clamp to [-2^(BW_OUT-1), 2^(BW_OUT-1)-1]. `sat`=1 when clamping occurred.
- Reset values:
  - FSM=RUN, `cnt`=0, `sum[]`=0.
  - c[0]=1 and all other coefficients 0, giving passthrough.
  - `out_valid`=0, `y_out`=0, `sat`=0.
- Boundary conditions:
  - `in_valid` and `coef_load` in the same RUN cycle: the sample is accepted and LOAD starts next cycle.
  - A sample already in flight when LOAD starts still emits its `out_valid` on schedule.
  - Reset mid-LOAD aborts the load. Partially written coefficients are discarded and the reset coefficients are restored.
  - Gaps on `in_valid` produce gaps on `out_valid`, with no duplicate or stale outputs.

## Timing
- A sample accepted at cycle t produces `out_valid`=1 at t+2 with y[n] = Σ c[k]·x[n-k] over accepted samples. Latency is exactly 2; throughput is 1 sample/cycle.
- `in_ready` is decoded from the state register only, with no combinational path from inputs.
- A load of N_TAPS words takes at least N_TAPS+1 cycles, counting the `coef_load` cycle. `in_ready` returns to 1 on the cycle after the last `coef_valid`.
- `out_valid` and `sat` are single-cycle strobes. `y_out` holds its value between strobes.

## Structure
- Shared package `fir_pkg`: FSM state enum {RUN, LOAD} and the `BW_ACC` derivation function.
- Sub-module `fir_out_stage`: round, shift and saturate, plus the output register, parametrised by BW_ACC, BW_OUT and SHIFT.
- Top module: FSM, coefficient bank, and generate loop over taps.

## Test plan
All scenarios use default parameters unless stated.
- Reset passthrough: after reset, x=5 then x=-8 → `y_out`=5 then -8, each 2 cycles after accept, `sat`=0.
- Impulse: load [1,2,3,4], then x=1,0,0,0,0 → y=1,2,3,4,0.
- Saturation: load [-8,-8,-8,-8], feed x=-8 four times → fourth y=127 (true value 256) with `sat`=1; first y=64 with `sat`=0.
- Rounding (SHIFT=2): with coefficients [1,0,0,0], x=6 → 2, x=-6 → -1, x=5 → 1.
- Load mid-stream: pulse `coef_load` while streaming and hold `in_valid`=1 → `in_ready`=0 for N_TAPS+1 cycles and no samples are accepted. The in-flight output still appears. The first post-load output depends on the new sample only.
- Reset mid-LOAD after 2 words → RUN with `in_ready`=1, and passthrough behaviour is restored (x=3 → y=3).
